// File: rtl/uart_core_cfg.sv
// Parametrised full-duplex UART: configurable width, parity and stop bits,
// oversampled majority-vote receiver and ready/valid handshakes on both sides.
module uart_core_cfg #(
    parameter int CLK_FREQUENCY = 48000000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_vld,
    output logic                 tx_rdy,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_uart,
    input  logic                 rx_uart,
    output logic                 rx_valid,
    input  logic                 rx_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int SAMPLE_RATE = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_ROUND   = (CLK_FREQUENCY + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int BAUD_DIV    = (DIV_ROUND < 1) ? 1 : DIV_ROUND;
    localparam int BIT_CLKS    = BAUD_DIV * OVERSAMPLE;

    localparam int BIT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_CLKS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BAUD_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_C     = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY != 0);
    localparam logic             ODD_PARITY = (PARITY == 1);

    generate
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_core_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_core_cfg: STOP_BITS must be 1 or 2");
        end
        if (OVERSAMPLE % 2 != 0 || OVERSAMPLE < 8) begin : g_bad_os
            $error("uart_core_cfg: OVERSAMPLE must be even and at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("uart_core_cfg: DATA_BITS must be within 5..9");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    tx_state_t            tx_state;
    tx_state_t            tx_next;
    logic [BIT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_line;
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_rdy     = (tx_state == TX_IDLE);
    assign tx_uart    = tx_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_vld) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA: begin
                if (tx_bit_end && tx_idx == DATA_LAST) begin
                    tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_idx == STOP_LAST) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // The line is registered and loaded with the upcoming bit at each boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_vld) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_shift <= tx_data;
                        tx_par   <= ODD_PARITY ? ~^tx_data : ^tx_data;
                        tx_line  <= 1'b0;
                    end
                end
                TX_START: begin
                    tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                    if (tx_bit_end) tx_line <= tx_shift[0];
                end
                TX_DATA: begin
                    tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                    if (tx_bit_end) begin
                        tx_shift <= tx_shift >> 1;
                        if (tx_idx == DATA_LAST) begin
                            tx_idx  <= '0;
                            tx_line <= HAS_PARITY ? tx_par : 1'b1;
                        end else begin
                            tx_idx  <= tx_idx + 1'b1;
                            tx_line <= tx_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                    if (tx_bit_end) tx_line <= 1'b1;
                end
                TX_STOP: begin
                    tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                    if (tx_bit_end) begin
                        tx_idx  <= tx_idx + 1'b1;
                        tx_line <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    rx_state_t            rx_state;
    rx_state_t            rx_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 rx_fall;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic                 tick;
    logic                 mid_done;
    logic                 rx_bit_end;
    logic                 smp_a;
    logic                 smp_b;
    logic                 vote;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 stop_eval;
    logic                 good_stop;
    logic                 par_bad;
    logic                 held;
    logic                 new_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_uart;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall    = rx_prev & ~rx_s;
    assign tick       = (div_cnt == DIV_LAST);
    assign mid_done   = tick && (os_cnt == SMP_C);
    assign rx_bit_end = tick && (os_cnt == OS_LAST);
    assign vote       = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: begin
                if (mid_done && vote) begin
                    rx_next = RX_IDLE;
                end else if (rx_bit_end) begin
                    rx_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end && rx_idx == DATA_LAST) begin
                    rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
            RX_STOP:   if (mid_done) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    // Counters idle at zero so a start edge always begins a fresh bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            os_cnt     <= '0;
            smp_a      <= 1'b1;
            smp_b      <= 1'b1;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
            rx_idx  <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            if (tick && os_cnt == SMP_A) smp_a <= rx_s;
            if (tick && os_cnt == SMP_B) smp_b <= rx_s;
            if (rx_state == RX_DATA) begin
                if (mid_done) rx_shift <= {vote, rx_shift[DATA_BITS-1:1]};
                if (rx_bit_end) rx_idx <= rx_idx + 1'b1;
            end
            if (rx_state == RX_PARITY && mid_done) rx_par_bit <= vote;
        end
    end

    assign stop_eval = (rx_state == RX_STOP) && mid_done;
    assign good_stop = stop_eval && vote;
    assign par_bad   = HAS_PARITY && (rx_par_bit != (ODD_PARITY ? ~^rx_shift : ^rx_shift));
    assign held      = rx_valid && !rx_rdy;
    assign new_word  = good_stop && !par_bad && !held;

    // Error priority: framing, then parity, then overrun of a still-held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err  <= stop_eval && !vote;
            rx_parity_err <= good_stop && par_bad;
            rx_overrun    <= good_stop && !par_bad && held;
            if (new_word) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_rdy) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Self-checking bench for uart_core_cfg: an 8E1 instance driven by directed and
// random frames, and a 7N2 looped-back instance for TX pacing and reset abort.
module tb_uart_core_cfg;

    localparam int BIT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic       tx_vld_a, tx_rdy_a, tx_uart_a, rx_uart_a, rx_valid_a, rx_rdy_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       fe_pin_a, pe_pin_a, ov_pin_a;
    logic       loop_a, rx_drv_a;

    logic       tx_vld_b, tx_rdy_b, tx_uart_b, rx_uart_b, rx_valid_b, rx_rdy_b;
    logic [6:0] tx_data_b, rx_data_b;
    logic       fe_pin_b, pe_pin_b, ov_pin_b;

    assign rx_uart_a = loop_a ? tx_uart_a : rx_drv_a;
    assign rx_uart_b = tx_uart_b;
    assign rx_rdy_b  = 1'b1;

    uart_core_cfg #(
        .CLK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)
    ) dut_a (
        .clk(clk), .reset(reset),
        .tx_vld(tx_vld_a), .tx_rdy(tx_rdy_a), .tx_data(tx_data_a), .tx_uart(tx_uart_a),
        .rx_uart(rx_uart_a), .rx_valid(rx_valid_a), .rx_rdy(rx_rdy_a), .rx_data(rx_data_a),
        .rx_frame_err(fe_pin_a), .rx_parity_err(pe_pin_a), .rx_overrun(ov_pin_a)
    );

    uart_core_cfg #(
        .CLK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(7),
        .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)
    ) dut_b (
        .clk(clk), .reset(reset),
        .tx_vld(tx_vld_b), .tx_rdy(tx_rdy_b), .tx_data(tx_data_b), .tx_uart(tx_uart_b),
        .rx_uart(rx_uart_b), .rx_valid(rx_valid_b), .rx_rdy(rx_rdy_b), .rx_data(rx_data_b),
        .rx_frame_err(fe_pin_b), .rx_parity_err(pe_pin_b), .rx_overrun(ov_pin_b)
    );

    // Monitors: count pulse-high cycles and collect accepted words.
    int fe_a = 0, pe_a = 0, ov_a = 0, fe_b = 0, pe_b = 0, ov_b = 0, stab_a = 0;
    logic [7:0] q_a[$];
    logic [6:0] q_b[$];
    logic       prev_hold_a = 1'b0;
    logic [7:0] prev_data_a = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid_a && rx_rdy_a) q_a.push_back(rx_data_a);
            if (rx_valid_b && rx_rdy_b) q_b.push_back(rx_data_b);
            if (prev_hold_a && (!rx_valid_a || rx_data_a !== prev_data_a)) stab_a++;
            prev_hold_a = rx_valid_a && !rx_rdy_a;
            prev_data_a = rx_data_a;
            fe_a += int'(fe_pin_a);
            pe_a += int'(pe_pin_a);
            ov_a += int'(ov_pin_a);
            fe_b += int'(fe_pin_b);
            pe_b += int'(pe_pin_b);
            ov_b += int'(ov_pin_b);
        end
    end

    function automatic logic par_bit(input logic [8:0] d, input int n, input int mode);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(d[i]);
        return (mode == 1) ? logic'((c + 1) % 2) : logic'(c % 2);
    endfunction

    // Frame bits in line order, index 0 = start bit; unused upper bits are stop/idle ones.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int n, input int mode);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < n; i++) f[1+i] = d[i];
        if (mode != 0) f[1+n] = par_bit(d, n, mode);
        return f;
    endfunction

    function automatic logic [7:0] pop_a();
        if (q_a.size() == 0) return 8'hxx;
        return q_a.pop_front();
    endfunction

    function automatic logic [6:0] pop_b();
        if (q_b.size() == 0) return 7'hxx;
        return q_b.pop_front();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8E1 frame on dut_a's line; glitch inverts the line for one cycle.
    task automatic apply_stimulus(input logic [7:0] d, input logic par_flip,
                                  input logic stop_val, input int glitch);
        logic [15:0] f;
        f = frame_bits({1'b0, d}, 8, 2);
        f[9]  = f[9] ^ par_flip;
        f[10] = stop_val;
        for (int c = 0; c < 11 * BIT; c++) begin
            rx_drv_a = f[c/BIT] ^ (c == glitch);
            step();
        end
        rx_drv_a = 1'b1;
    endtask

    logic       line_cap [200];
    logic [15:0] fexp;
    logic [7:0] exp_q[$];
    logic [6:0] d_b [3];
    int exp_fe, exp_pe, exp_ov, rdy_at, cnt, kind, acc, low;
    int gaps [2];
    logic [7:0] rd;
    logic prev_rdy;

    initial begin
        reset = 1'b1;
        tx_vld_a = 1'b0; tx_data_a = 8'h00; loop_a = 1'b0; rx_drv_a = 1'b1; rx_rdy_a = 1'b1;
        tx_vld_b = 1'b0; tx_data_b = 7'h00;
        exp_fe = 0; exp_pe = 0; exp_ov = 0;
        idle(3);
        check_output("reset_tx_uart_a", tx_uart_a, 1);
        check_output("reset_tx_rdy_a", tx_rdy_a, 1);
        check_output("reset_rx_valid_a", rx_valid_a, 0);
        check_output("reset_rx_data_a", rx_data_a, 0);
        check_output("reset_err_pins_a", {fe_pin_a, pe_pin_a, ov_pin_a}, 0);
        check_output("reset_tx_uart_b", tx_uart_b, 1);
        check_output("reset_tx_rdy_b", tx_rdy_b, 1);
        check_output("reset_rx_valid_b", rx_valid_b, 0);
        reset = 1'b0;
        idle(5);

        // Loopback transmit of 0xA5 on the 8E1 instance.
        loop_a = 1'b1;
        tx_data_a = 8'hA5;
        tx_vld_a = 1'b1;
        step();
        tx_vld_a = 1'b0;
        tx_data_a = 8'($urandom);
        rdy_at = -1;
        for (int i = 0; i < 200; i++) begin
            line_cap[i] = tx_uart_a;
            if (rdy_at < 0 && tx_rdy_a) rdy_at = i;
            step();
        end
        fexp = frame_bits({1'b0, 8'hA5}, 8, 2);
        for (int k = 0; k < 11; k++) begin
            cnt = 0;
            for (int j = 0; j < BIT; j++) cnt += int'(line_cap[k*BIT+j] === fexp[k]);
            check_output($sformatf("tx_bit%0d_cycles", k), cnt, BIT);
        end
        check_output("tx_parity_bit", line_cap[9*BIT+8], par_bit({1'b0, 8'hA5}, 8, 2));
        check_output("tx_rdy_return", rdy_at, 11 * BIT);
        check_output("tx_idle_after", line_cap[190], 1);
        check_output("loop_word_count", q_a.size(), 1);
        check_output("loop_word", pop_a(), 8'hA5);
        check_output("loop_no_errors", fe_a + pe_a + ov_a, 0);
        loop_a = 1'b0;
        idle(10);

        // Wrong parity bit.
        apply_stimulus(8'h3C, 1'b1, 1'b1, -1);
        idle(20);
        exp_pe++;
        check_output("parity_err_pulse", pe_a, exp_pe);
        check_output("parity_no_frame_err", fe_a, exp_fe);
        check_output("parity_no_word", q_a.size(), 0);
        check_output("parity_rx_valid", rx_valid_a, 0);

        // Low stop bit, then a clean frame.
        apply_stimulus(8'h55, 1'b0, 1'b0, -1);
        idle(2 * BIT);
        exp_fe++;
        check_output("frame_err_pulse", fe_a, exp_fe);
        check_output("frame_no_word", q_a.size(), 0);
        apply_stimulus(8'h12, 1'b0, 1'b1, -1);
        idle(20);
        check_output("after_frame_err_word", pop_a(), 8'h12);
        check_output("after_frame_err_fe", fe_a, exp_fe);

        // Overrun: two back-to-back frames with the consumer stalled.
        rx_rdy_a = 1'b0;
        apply_stimulus(8'h11, 1'b0, 1'b1, -1);
        apply_stimulus(8'h22, 1'b0, 1'b1, -1);
        idle(20);
        exp_ov++;
        check_output("overrun_valid_held", rx_valid_a, 1);
        check_output("overrun_data_held", rx_data_a, 8'h11);
        check_output("overrun_pulse", ov_a, exp_ov);
        rx_rdy_a = 1'b1;
        step();
        check_output("overrun_valid_clears", rx_valid_a, 0);
        check_output("overrun_word", pop_a(), 8'h11);
        check_output("overrun_dropped", q_a.size(), 0);

        // False start glitch, then a glitched data bit.
        rx_drv_a = 1'b0;
        idle(4);
        rx_drv_a = 1'b1;
        idle(40);
        check_output("false_start_no_word", q_a.size(), 0);
        check_output("false_start_no_valid", rx_valid_a, 0);
        check_output("false_start_no_err", fe_a + pe_a + ov_a, exp_fe + exp_pe + exp_ov);
        apply_stimulus(8'hFF, 1'b0, 1'b1, 4 * BIT + 9);
        idle(20);
        check_output("glitch_vote_word", pop_a(), 8'hFF);

        // Random frames against the frame-outcome model.
        for (int n = 0; n < 8; n++) begin
            rd = 8'($urandom);
            kind = int'($urandom_range(0, 2));
            apply_stimulus(rd, kind == 1, kind != 2, -1);
            if (kind == 0) exp_q.push_back(rd);
            if (kind == 1) exp_pe++;
            if (kind == 2) exp_fe++;
            idle(int'($urandom_range(1, 20)) + ((kind == 2) ? BIT : 0));
        end
        idle(20);
        check_output("rand_word_count", q_a.size(), exp_q.size());
        while (exp_q.size() > 0) check_output("rand_word", pop_a(), exp_q.pop_front());
        check_output("rand_frame_errs", fe_a, exp_fe);
        check_output("rand_parity_errs", pe_a, exp_pe);
        check_output("rand_overruns", ov_a, exp_ov);
        check_output("rx_data_stable", stab_a, 0);

        // 7N2 back-to-back transmit with tx_vld held.
        d_b[0] = 7'h7F;
        d_b[1] = 7'($urandom);
        d_b[2] = 7'($urandom);
        tx_data_b = d_b[0];
        tx_vld_b = 1'b1;
        prev_rdy = tx_rdy_b;
        acc = 0;
        low = 0;
        gaps[0] = -1;
        gaps[1] = -1;
        for (int i = 0; i < 800 && acc < 3; i++) begin
            step();
            if (prev_rdy) begin
                if (acc > 0) gaps[acc-1] = low;
                low = 0;
                acc++;
                if (acc < 3) tx_data_b = d_b[acc];
                else tx_vld_b = 1'b0;
            end
            if (!tx_rdy_b) low++;
            prev_rdy = tx_rdy_b;
        end
        check_output("b2b_accepts", acc, 3);
        check_output("b2b_gap0", gaps[0], (1 + 7 + 2) * BIT);
        check_output("b2b_gap1", gaps[1], (1 + 7 + 2) * BIT);
        idle(200);
        check_output("b_word_count", q_b.size(), 3);
        for (int k = 0; k < 3; k++) check_output($sformatf("b_word%0d", k), pop_b(), d_b[k]);
        check_output("b_no_errors", fe_b + pe_b + ov_b, 0);

        // Reset during the start bit aborts the frame.
        tx_data_b = 7'($urandom);
        tx_vld_b = 1'b1;
        step();
        tx_vld_b = 1'b0;
        idle(5);
        check_output("midframe_line_low", tx_uart_b, 0);
        check_output("midframe_busy", tx_rdy_b, 0);
        reset = 1'b1;
        step();
        check_output("abort_tx_uart", tx_uart_b, 1);
        check_output("abort_tx_rdy", tx_rdy_b, 1);
        reset = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
Parametrised full-duplex UART. Generalises the fixed 8N1 transceiver with:
- configurable data width, parity mode and stop-bit count
- 16x (parametrised) oversampled RX with 2-FF input synchroniser and 3-sample majority vote
- ready/valid handshakes on both sides, with a one-entry RX holding register
- separate framing, parity and overrun error pulses

Sits between the host-side streaming fabric and the board-level UART pins.

Parameters:
CLK_FREQUENCY, 48000000, system clock in Hz
BAUD_RATE, 115200, line rate in baud
DATA_BITS, 8, payload bits per frame (5..9)
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, stop bits generated by TX (1 or 2); RX checks only the first
OVERSAMPLE, 16, RX ticks per bit (even, >=8)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tx_vld  in  1  TX word valid
tx_rdy  out  1  TX ready to accept a word
tx_data  in  DATA_BITS  TX payload, sent LSB first
tx_uart  out  1  serial line out (idle high)
rx_uart  in  1  serial line in (asynchronous)
rx_valid  out  1  RX word valid, held until accepted
rx_rdy  in  1  consumer ready
rx_data  out  DATA_BITS  received payload
rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
rx_parity_err  out  1  one-cycle pulse: parity mismatch
rx_overrun  out  1  one-cycle pulse: frame finished while rx_valid still pending

Behaviour:
Reset:
- clk and reset: reset is synchronous, active-high; clock is clk.
- Reset values: tx_uart=1, tx_rdy=1, rx_valid=0, rx_data=0, all error pulses=0; both FSMs go to IDLE.
- Reset mid-frame aborts immediately; tx_uart is high on the cycle after reset is sampled.

Timing constants:
- BAUD_DIV = max(1, round(CLK_FREQUENCY / (BAUD_RATE*OVERSAMPLE))).
- BIT_CLKS = BAUD_DIV*OVERSAMPLE.
- Counter widths come from $clog2 of these constants; counters compare with ==, never wrap past their terminal value.
- Elaboration error if PARITY>2, STOP_BITS not 1/2, or OVERSAMPLE odd.

TX FSM (IDLE -> START -> DATA -> PARITY(skipped if PARITY=0) -> STOP -> IDLE):
- Transfer occurs when tx_vld && tx_rdy.
- On transfer: latch tx_data; compute parity bit (even: XOR of data; odd: its inverse); tx_rdy=0 next cycle.
- Line sequence: tx_uart=0 from the cycle after acceptance, for exactly BIT_CLKS cycles.
- Each data/parity/stop bit lasts BIT_CLKS; the bit-period counter restarts at acceptance.
- After STOP_BITS*BIT_CLKS of stop, tx_rdy=1 in the next cycle.
- Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BIT_CLKS cycles.
- tx_vld while busy is ignored; tx_data need not be held after acceptance.

RX synchroniser and tick:
- rx_uart passes through 2 FFs (rx_s). Tick counter fires every BAUD_DIV clocks.

RX FSM (IDLE -> START -> DATA -> PARITY(skipped if PARITY=0) -> STOP -> IDLE):
- IDLE: a falling edge on rx_s resets the tick and sample counters, then enter START.
- Per bit, rx_s is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; bit value = majority of 3.
- START: majority 1 -> false start; return to IDLE, no error, no output.
- DATA: shift bits in LSB first.
- PARITY: compare against the computed parity.
- STOP: evaluated at the mid-bit majority, then FSM returns to IDLE immediately. This allows back-to-back frames with a half-bit margin.

RX output / errors, at stop evaluation:
- Stop bit = 0: pulse rx_frame_err; word discarded.
- Otherwise, parity mismatch: pulse rx_parity_err; word discarded.
- Otherwise, if rx_valid=1 and rx_rdy=0 that same cycle: pulse rx_overrun; new word dropped, held word preserved.
- Otherwise: rx_data updated and rx_valid=1 on the next cycle.
- rx_valid clears the cycle after rx_valid && rx_rdy.
- If acceptance and a new word coincide, the new word loads and rx_valid stays 1 (no overrun).
- rx_data is stable while rx_valid=1.

Simultaneous TX and RX activity are fully independent.

Test Plan:
1. CLK_FREQUENCY=1600000, BAUD_RATE=100000 (BIT_CLKS=16), PARITY=2, tx_uart looped to rx_uart, send 0xA5 -> tx_uart low 16 cycles, parity bit 0, tx_rdy high 176 cycles after acceptance; rx_data=0xA5, one rx_valid, no errors.
2. Same config, rx_uart driven with 0x3C and wrong parity bit 1 -> rx_parity_err single pulse, rx_valid stays 0.
3. Drive frame 0x55 with stop bit held 0 -> rx_frame_err pulse; then line high and a valid 0x12 frame -> rx_data=0x12 received correctly.
4. rx_rdy=0; two valid frames 0x11 then 0x22 -> rx_valid=1 with rx_data=0x11; rx_overrun pulses at the second stop; rx_data still 0x11 after rx_rdy=1.
5. 4-cycle low glitch on rx_uart in IDLE -> false start; no rx_valid, no errors. Single-cycle glitch at mid data bit of 0xFF -> majority vote still yields 0xFF.
6. PARITY=0, STOP_BITS=2, DATA_BITS=7: send 0x7F back-to-back with tx_vld held -> tx_rdy gaps of exactly 10*16 cycles between acceptances. Assert reset mid-frame -> tx_uart=1 and tx_rdy=1 the next cycle.
